// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline hazard controller. Detects load-use and
//                branch-compare hazards, selects execute-stage operand
//                forwarding, and sequences multi-cycle multiply/divide
//                occupancy. It is the single source of every stall and
//                flush control in the pipeline.
//
//  Parameters  : MD_LAT  multiply/divide occupancy in cycles, including the
//                        issue cycle (2..16)
//                RW      register-address width
//
//  Ports       : CLK, RST               clock / asynchronous active-high reset
//                RsD, RtD               decode-stage source registers
//                RsE, RtE               execute-stage source registers
//                WriteReg{E,M,W}        destination registers of E, M, W
//                RegWrite{E,M,W}        destination write-enables
//                MemtoReg{E,M}          instruction is a load
//                BranchD, PCSrcD        decode branch / branch resolved taken
//                MdStartE               multiply/divide issued in E
//                StallF, StallD         PC / decode-register hold (1 = hold)
//                FlushD, FlushE         decode / execute register clear
//                ForwardAE, ForwardBE   00 = regfile, 01 = W, 10 = M
//                MdBusy                 multiply/divide in progress
//                StallCount             saturating stall-cycle counter
//                                       (present only with HAZARD_STALL_CNT_EN)
//
//  Build option: define HAZARD_STALL_CNT_EN to add the StallCount output.
//
//  Revision    : 1.0  initial release
// ============================================================================

module hazard_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int RW     = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [RW-1:0] RsD,
    input  logic [RW-1:0] RtD,
    input  logic [RW-1:0] RsE,
    input  logic [RW-1:0] RtE,
    input  logic [RW-1:0] WriteRegE,
    input  logic [RW-1:0] WriteRegM,
    input  logic [RW-1:0] WriteRegW,
    input  logic          RegWriteE,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          MemtoRegE,
    input  logic          MemtoRegM,
    input  logic          BranchD,
    input  logic          PCSrcD,
    input  logic          MdStartE,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          MdBusy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]   StallCount
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // The issue cycle itself is not a BUSY cycle, and the counter spends
    // one extra cycle at zero, so MD_LAT-2 gives MD_LAT-1 BUSY cycles.
    localparam logic [3:0] C_CNT_LOAD = 4'(MD_LAT - 2);

    localparam logic [1:0] C_FWD_RF = 2'b00;
    localparam logic [1:0] C_FWD_W  = 2'b01;
    localparam logic [1:0] C_FWD_M  = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Multiply/divide sequencer state
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_e_hits_d;     // E destination matches a decode source
    logic w_m_hits_d;     // M destination matches a decode source
    logic w_lwstall;
    logic w_brstall;
    logic w_md_busy;
    logic w_hazard;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign w_e_hits_d = (WriteRegE != '0) &&
                        ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign w_m_hits_d = (WriteRegM != '0) &&
                        ((WriteRegM == RsD) || (WriteRegM == RtD));

    assign w_lwstall = MemtoRegE && RegWriteE && w_e_hits_d;

    // A branch compares in decode, so it must wait for any ALU result still
    // in E and for any load result still in M (not yet forwardable).
    assign w_brstall = BranchD &&
                       ((RegWriteE && w_e_hits_d) || (MemtoRegM && w_m_hits_d));

    assign w_md_busy = (state_q == S_BUSY);
    assign w_hazard  = w_lwstall || w_brstall || w_md_busy;

    // ------------------------------------------------------------------
    // Forwarding selection (M has priority: it holds the newer value)
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
        logic [1:0] sel;
        sel = C_FWD_RF;
        if (src != '0) begin
            if (RegWriteM && (WriteRegM == src)) begin
                sel = C_FWD_M;
            end else if (RegWriteW && (WriteRegW == src)) begin
                sel = C_FWD_W;
            end
        end
        return sel;
    endfunction

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_fwd_a = fwd_sel(RsE);
    assign w_fwd_b = fwd_sel(RtE);

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (MdStartE) begin
                    state_d = S_BUSY;
                    cnt_d   = C_CNT_LOAD;
                end
            end
            S_BUSY: begin
                // A new MdStartE here is deliberately ignored: the unit is
                // occupied and the issuing instruction is held upstream.
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs (combinational; reset forces a safe pattern that
    // clears both pipeline registers and releases all holds)
    // ------------------------------------------------------------------
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = C_FWD_RF;
        ForwardBE = C_FWD_RF;
        MdBusy    = 1'b0;
        if (!RST) begin
            StallF    = w_hazard;
            StallD    = w_hazard;
            // While decode holds, a bubble goes into E instead.
            FlushE    = w_hazard;
            // A held instruction must never be cleared, so stall beats flush.
            FlushD    = PCSrcD && !w_hazard;
            ForwardAE = w_fwd_a;
            ForwardBE = w_fwd_b;
            MdBusy    = w_md_busy;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Saturating count of decode-stall cycles
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Directed self-checking bench for hazard_stall_ctrl
//                (MD_LAT = 4, RW = 5). Expected control patterns are queued
//                as stimulus is applied and compared once outputs settle.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_hazard_stall_ctrl;

    localparam int RW = 5;

    logic          clk;
    logic          rst;
    logic [RW-1:0] RsD, RtD, RsE, RtE;
    logic [RW-1:0] WriteRegE, WriteRegM, WriteRegW;
    logic          RegWriteE, RegWriteM, RegWriteW;
    logic          MemtoRegE, MemtoRegM;
    logic          BranchD, PCSrcD, MdStartE;
    logic          StallF, StallD, FlushD, FlushE, MdBusy;
    logic [1:0]    ForwardAE, ForwardBE;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0]   StallCount;
`endif

    hazard_stall_ctrl #(
        .MD_LAT (4),
        .RW     (RW)
    ) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegE (WriteRegE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteE (RegWriteE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .MemtoRegE (MemtoRegE),
        .MemtoRegM (MemtoRegM),
        .BranchD   (BranchD),
        .PCSrcD    (PCSrcD),
        .MdStartE  (MdStartE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .MdBusy    (MdBusy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .StallCount(StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output pattern for one cycle.
    typedef struct packed {
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_inputs();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0;
        BranchD = 1'b0; PCSrcD = 1'b0; MdStartE = 1'b0;
    endtask

    // Queue the expectation for the stimulus just applied, let outputs settle
    // to the falling edge, compare, then advance to just after the next
    // rising edge so new stimulus is applied away from the clock.
    task automatic step(input string tag, input logic sf, input logic sd,
                        input logic fd, input logic fe, input logic [1:0] fa,
                        input logic [1:0] fb, input logic busy);
        exp_t  e;
        string t;
        e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe;
        e.fa = fa; e.fb = fb; e.busy = busy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".StallF"},    32'(StallF),    32'(e.sf));
        chk({t, ".StallD"},    32'(StallD),    32'(e.sd));
        chk({t, ".FlushD"},    32'(FlushD),    32'(e.fd));
        chk({t, ".FlushE"},    32'(FlushE),    32'(e.fe));
        chk({t, ".ForwardAE"}, 32'(ForwardAE), 32'(e.fa));
        chk({t, ".ForwardBE"}, 32'(ForwardBE), 32'(e.fb));
        chk({t, ".MdBusy"},    32'(MdBusy),    32'(e.busy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        clr_inputs();

        // Reset forces the safe pattern even with a forwarding match present.
        rst = 1'b1;
        RegWriteM = 1'b1; WriteRegM = 5'd3; RsE = 5'd3;
        step("reset", 0, 0, 1, 1, 2'b00, 2'b00, 0);
`ifdef HAZARD_STALL_CNT_EN
        chk("cnt_reset", StallCount, 32'd0);
`endif
        rst = 1'b0;
        clr_inputs();
        step("idle", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Load-use via RsD, with a taken branch that must not flush.
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8; PCSrcD = 1'b1;
        step("lw_rs", 1, 1, 0, 1, 2'b00, 2'b00, 0);
        clr_inputs(); PCSrcD = 1'b1;
        step("lw_gone_flush", 0, 0, 1, 0, 2'b00, 2'b00, 0);
        clr_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
        step("lw_rt", 1, 1, 0, 1, 2'b00, 2'b00, 0);
        clr_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0; RsD = 5'd0;
        step("lw_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Forwarding: M over W, register 0 never forwarded, W fallback.
        clr_inputs();
        RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd3; WriteRegW = 5'd3; RsE = 5'd3;
        step("fwd_m_pri", 0, 0, 0, 0, 2'b10, 2'b00, 0);
        RsE = 5'd0;
        step("fwd_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        RsE = 5'd3; RegWriteM = 1'b0;
        step("fwd_w", 0, 0, 0, 0, 2'b01, 2'b00, 0);
        RegWriteM = 1'b1; WriteRegM = 5'd4; RsE = 5'd4; RtE = 5'd3;
        step("fwd_split", 0, 0, 0, 0, 2'b10, 2'b01, 0);
        WriteRegM = 5'd3; RsE = 5'd7;
        step("fwd_b_m", 0, 0, 0, 0, 2'b00, 2'b10, 0);

        // Branch compare hazards.
        clr_inputs();
        BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd1; RtD = 5'd2;
        step("br_nodep", 0, 0, 1, 0, 2'b00, 2'b00, 0);
        RegWriteE = 1'b1; WriteRegE = 5'd5; RtD = 5'd5;
        step("br_e_dep", 1, 1, 0, 1, 2'b00, 2'b00, 0);
        clr_inputs();
        BranchD = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd6; RsD = 5'd6;
        step("br_m_load", 1, 1, 0, 1, 2'b00, 2'b00, 0);
        WriteRegM = 5'd0; RsD = 5'd0;
        step("br_m_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        clr_inputs();
        RegWriteE = 1'b1; WriteRegE = 5'd5; RtD = 5'd5;
        step("nobr_alu", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Multiply/divide: 3 busy cycles; second pulse during BUSY ignored.
        clr_inputs();
        MdStartE = 1'b1;
        step("md_issue", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        MdStartE = 1'b0;
        step("md_b1", 1, 1, 0, 1, 2'b00, 2'b00, 1);
        MdStartE = 1'b1; PCSrcD = 1'b1;
        step("md_b2_restart", 1, 1, 0, 1, 2'b00, 2'b00, 1);
        MdStartE = 1'b0; PCSrcD = 1'b0;
        step("md_b3", 1, 1, 0, 1, 2'b00, 2'b00, 1);
        step("md_done", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        step("md_stays_idle", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Reset in the second BUSY cycle acts without waiting for an edge.
        MdStartE = 1'b1;
        step("mdr_issue", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        MdStartE = 1'b0;
        step("mdr_b1", 1, 1, 0, 1, 2'b00, 2'b00, 1);
        rst = 1'b1;
        step("mdr_async_rst", 0, 0, 1, 1, 2'b00, 2'b00, 0);
        rst = 1'b0;
        step("mdr_release", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        step("mdr_fresh", 0, 0, 0, 0, 2'b00, 2'b00, 0);

`ifdef HAZARD_STALL_CNT_EN
        // Counter: 3 multiply/divide stall cycles plus one load-use stall.
        rst = 1'b1;
        step("cnt_rst0", 0, 0, 1, 1, 2'b00, 2'b00, 0);
        rst = 1'b0;
        MdStartE = 1'b1;
        step("cnt_issue", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        MdStartE = 1'b0;
        step("cnt_b1", 1, 1, 0, 1, 2'b00, 2'b00, 1);
        step("cnt_b2", 1, 1, 0, 1, 2'b00, 2'b00, 1);
        step("cnt_b3", 1, 1, 0, 1, 2'b00, 2'b00, 1);
        chk("cnt_after_md", StallCount, 32'd3);
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        step("cnt_lw", 1, 1, 0, 1, 2'b00, 2'b00, 0);
        clr_inputs();
        chk("cnt_total", StallCount, 32'd4);
        rst = 1'b1;
        #1;
        chk("cnt_cleared", StallCount, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller: the producer of the stall (active-low enable) and clear (flush) controls consumed by the fetch-to-decode register, and of the equivalent controls for the PC and the decode-to-execute register.
- Detects load-use and branch-compare hazards and selects execute-stage forwarding.
- Sequences multi-cycle multiply/divide stalls with an internal FSM and counter.
- Sits beside the datapath and is the single source of every stall and flush signal.

Parameters:
- MD_LAT, 4: multiply/divide occupancy in cycles, including the issue cycle; legal range 2..16.
- RW, 5: register-address width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- RsD, RtD  in  RW  decode-stage source registers.
- RsE, RtE  in  RW  execute-stage source registers.
- WriteRegE, WriteRegM, WriteRegW  in  RW  destination registers of E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write-enables.
- MemtoRegE, MemtoRegM  in  1  instruction is a load.
- BranchD  in  1  decode-stage branch.
- PCSrcD  in  1  branch resolved taken.
- MdStartE  in  1  multiply/divide issued in E.
- StallF  out  1  drives PC enable; 1 = hold.
- StallD  out  1  drives decode-register EN; 1 = hold.
- FlushD  out  1  drives decode-register CLR.
- FlushE  out  1  clear of the decode-to-execute register.
- ForwardAE, ForwardBE  out  2  E operand select: 00 = register file, 01 = W result, 10 = M result.
- MdBusy  out  1  multiply/divide in progress.

Behaviour:
- Register 0 is never a hazard source and is never forwarded.
- lwstall = MemtoRegE & RegWriteE & (WriteRegE != 0) & (WriteRegE == RsD | WriteRegE == RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE != 0 & WriteRegE matches RsD or RtD) | (MemtoRegM & WriteRegM != 0 & WriteRegM matches RsD or RtD)).
- Forwarding is combinational:
  - ForwardAE = 10 if RegWriteM & WriteRegM != 0 & WriteRegM == RsE.
  - Otherwise ForwardAE = 01 if the same condition holds for W.
  - Otherwise ForwardAE = 00.
  - M has priority over W. ForwardBE is identical using RtE.
- FSM states: IDLE, BUSY. 4-bit counter cnt.
  - IDLE: MdStartE at posedge moves to BUSY and loads cnt = MD_LAT-2.
  - BUSY: cnt decrements each posedge; at cnt == 0 the next posedge returns to IDLE.
  - Total BUSY duration is MD_LAT-1 cycles.
  - MdStartE is ignored while in BUSY.
- MdBusy = (state == BUSY).
- StallF = StallD = lwstall | brstall | MdBusy.
- FlushE = lwstall | brstall | MdBusy; a bubble is inserted while decode holds.
- FlushD = PCSrcD & ~StallD. A stall wins over a flush: a held instruction is never cleared.
- Reset, asserted asynchronously:
  - state = IDLE, cnt = 0.
  - While RST is high, outputs are forced to StallF = StallD = 0, FlushD = FlushE = 1, Forward* = 00, MdBusy = 0.
  - Reset during BUSY aborts the operation immediately. After release the block behaves as freshly started.
- Control outputs are combinational from inputs and state: zero-cycle latency, no registered outputs.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - Adds output StallCount, 32 bits.
  - Increments on every posedge where StallD = 1 and RST = 0.
  - Saturates at 0xFFFFFFFF and clears to 0 on RST.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Load-use: MemtoRegE = 1, RegWriteE = 1, WriteRegE = 8, RsD = 8 -> StallF = StallD = FlushE = 1 for exactly that cycle; FlushD = 0 even with PCSrcD = 1.
- Forward priority: RegWriteM = RegWriteW = 1, WriteRegM = WriteRegW = RsE = 3 -> ForwardAE = 10. With RsE = 0 under the same setup -> ForwardAE = 00.
- Multiply/divide with MD_LAT = 4: MdStartE pulsed one cycle -> MdBusy, StallD and FlushE high for exactly 3 cycles, then 0. A second MdStartE pulse during BUSY does not extend the stall.
- Branch: BranchD = 1, PCSrcD = 1, no dependency -> FlushD = 1, StallD = 0. Then RegWriteE = 1 with WriteRegE = RtD = 5 -> StallD = 1, FlushD = 0.
- Reset mid-BUSY: RST asserted in the 2nd BUSY cycle -> MdBusy = 0 and FlushD = FlushE = 1 in the same cycle without waiting for an edge. After release with no hazards -> all outputs 0.
- HAZARD_STALL_CNT_EN defined: run the multiply/divide scenario (3 stall cycles) plus one load-use stall -> StallCount = 4. RST -> StallCount = 0.
